// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: loads H from memory or chains the last digest,
// runs the rounds on a streamed W schedule and writes the 8-word digest out.
module sha256_block_engine #(
    parameter int NUM_ROUNDS = 64,
    parameter int HMEM_AW    = 3,
    parameter int KMEM_AW    = 6,
    parameter int OUT_AW     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               chain,
    output logic [HMEM_AW-1:0] hmem_addr,
    output logic               hmem_en,
    input  logic [31:0]        hmem_data,
    output logic [KMEM_AW-1:0] kmem_addr,
    output logic               kmem_en,
    input  logic [31:0]        kmem_data,
    input  logic [31:0]        w_data,
    input  logic               w_valid,
    output logic               w_ready,
    output logic [31:0]        out_data,
    output logic [OUT_AW-1:0]  out_addr,
    output logic               out_en,
    output logic               out_we,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {IDLE, LOAD_H, ROUND, FINAL, WRITE, DONE} state_t;

    localparam logic [KMEM_AW-1:0] LAST_T = KMEM_AW'(NUM_ROUNDS - 1);
    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    state_t              state_q, state_d;
    logic [KMEM_AW-1:0]  t_q, t_d;
    logic                kv_q, kv_d;
    logic                kp_q, kp_d;
    logic [31:0]         k_q, k_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                hp_q, hp_d;
    logic [2:0]          hidx_q, hidx_d;
    logic [7:0][31:0]    wv_q, wv_d;
    logic [7:0][31:0]    base_q, base_d;
    logic [7:0][31:0]    dig_q, dig_d;

    logic [31:0] k_cur, s0, s1, chv, mjv, t1, t2;
    logic [31:0] a, b, c, e, f, g;
    logic        fire, last;

    // K arrives on the bus one cycle after issue; k_q holds it across stalls
    assign k_cur = kp_q ? kmem_data : k_q;

    assign a = wv_q[0];
    assign b = wv_q[1];
    assign c = wv_q[2];
    assign e = wv_q[4];
    assign f = wv_q[5];
    assign g = wv_q[6];

    assign s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    assign s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    assign chv = (e & f) ^ (~e & g);
    assign mjv = (a & b) ^ (a & c) ^ (b & c);
    assign t1  = wv_q[7] + s1 + chv + k_cur + w_data;
    assign t2  = s0 + mjv;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            kv_q    <= 1'b0;
            kp_q    <= 1'b0;
            k_q     <= '0;
            cnt_q   <= '0;
            hp_q    <= 1'b0;
            hidx_q  <= '0;
            wv_q    <= '0;
            base_q  <= '0;
            dig_q   <= IV;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            kv_q    <= kv_d;
            kp_q    <= kp_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            hidx_q  <= hidx_d;
            wv_q    <= wv_d;
            base_q  <= base_d;
            dig_q   <= dig_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        kv_d      = kv_q;
        kp_d      = 1'b0;
        k_d       = k_cur;
        cnt_d     = cnt_q;
        hp_d      = 1'b0;
        hidx_d    = hidx_q;
        wv_d      = wv_q;
        base_d    = base_q;
        dig_d     = dig_q;
        hmem_en   = 1'b0;
        hmem_addr = '0;
        kmem_en   = 1'b0;
        kmem_addr = '0;
        w_ready   = 1'b0;
        out_en    = 1'b0;
        out_we    = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        done      = 1'b0;
        busy      = (state_q != IDLE);
        fire      = 1'b0;
        last      = 1'b0;

        // H word 7 lands during the first ROUND cycle, before any round fires
        if (hp_q) begin
            base_d[hidx_q] = hmem_data;
            wv_d[hidx_q]   = hmem_data;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (chain) begin
                        wv_d    = dig_q;
                        base_d  = dig_q;
                        t_d     = '0;
                        kv_d    = 1'b0;
                        state_d = ROUND;
                    end else begin
                        state_d = LOAD_H;
                    end
                end
            end
            LOAD_H: begin
                hmem_en   = 1'b1;
                hmem_addr = HMEM_AW'(cnt_q);
                hp_d      = 1'b1;
                hidx_d    = cnt_q;
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    t_d     = '0;
                    kv_d    = 1'b0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                w_ready   = kv_q;
                fire      = w_valid & kv_q;
                last      = (t_q == LAST_T);
                kmem_addr = t_q + KMEM_AW'(kv_q);
                kmem_en   = !kv_q || (fire && !last);
                if (kmem_en) begin
                    kv_d = 1'b1;
                    kp_d = 1'b1;
                end
                if (fire) begin
                    wv_d    = {wv_q[6:0], t1 + t2};
                    wv_d[4] = wv_q[3] + t1;
                    t_d     = t_q + KMEM_AW'(1);
                    if (last) begin
                        kv_d    = 1'b0;
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    dig_d[i] = base_q[i] + wv_q[i];
                end
                cnt_d   = '0;
                state_d = WRITE;
            end
            WRITE: begin
                out_en   = 1'b1;
                out_we   = 1'b1;
                out_addr = OUT_AW'(cnt_q);
                out_data = dig_q[cnt_q];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/sha256_block_engine.md
# sha256_block_engine

Parametrised SHA-256 compression engine and successor to the single-shot hash datapath. It loads an initial hash state from H-memory, or chains from its own previous digest for multi-block messages, and runs the round function on a W-word stream with valid/ready back-pressure. K constants are read from K-memory. The feed-forward digest is written to the output memory, and a done pulse is raised. It sits between the message-schedule block (W producer) and the digest memory.

## Interface
- `NUM_ROUNDS`, 64, rounds per block; legal range 1..64, non-64 for reduced-round test only.
- `HMEM_AW`, 3, H-memory address width.
- `KMEM_AW`, 6, K-memory address width; must satisfy 2^KMEM_AW >= NUM_ROUNDS.
- `OUT_AW`, 3, output-memory address width.
- `clk`, in, 1, clock.
- `reset`, in, 1, synchronous, active-high.
- `start`, in, 1, one-cycle request to process one block; honoured only in IDLE.
- `chain`, in, 1, sampled with start: 0 = load H from hmem, 1 = reuse last digest.
- `hmem_addr`, out, HMEM_AW, H-memory read address.
- `hmem_en`, out, 1, H-memory read enable.
- `hmem_data`, in, 32, H word, valid 1 cycle after address/enable.
- `kmem_addr`, out, KMEM_AW, K-memory read address.
- `kmem_en`, out, 1, K-memory read enable.
- `kmem_data`, in, 32, K word, valid 1 cycle after address/enable.
- `w_data`, in, 32, schedule word W[t].
- `w_valid`, in, 1, W word present.
- `w_ready`, out, 1, engine consumes W this cycle when w_valid & w_ready.
- `out_data`, out, 32, digest word.
- `out_addr`, out, OUT_AW, digest word index (0 = H0).
- `out_en`, out, 1, output write strobe.
- `out_we`, out, 1, write qualifier; equals out_en.
- `busy`, out, 1, high in every state except IDLE.
- `done`, out, 1, one-cycle pulse after the last digest write.

## Operation
- FSM states: IDLE, LOAD_H, ROUND, FINAL, WRITE, DONE.
- IDLE:
  - start & !chain -> LOAD_H.
  - start & chain -> ROUND; the working state a..h and the saved base are both taken from the digest register.
  - start is ignored in all other states.
- LOAD_H:
  - Issue hmem addresses 0..7 on consecutive cycles.
  - Capture data one cycle later into both base H0..H7 and a..h.
  - After word 7 is captured -> ROUND.
- ROUND, round counter t = 0..NUM_ROUNDS-1:
  - kmem_addr = t is issued one cycle ahead (prefetch); a K-valid flag is set on data return.
  - w_ready = K-valid.
  - On w_valid & w_ready, one round is applied with 32-bit modulo arithmetic:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K + W.
    - T2 = Σ0(a) + Maj(a,b,c).
    - Σ1 = ROTR6^ROTR11^ROTR25. Σ0 = ROTR2^ROTR13^ROTR22.
    - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Then t increments and the next K is prefetched.
  - Stall (w_valid=0): state, t and K are held; kmem_en stays low.
  - After round NUM_ROUNDS-1 -> FINAL.
- FINAL: one cycle; digest Hi ← base Hi + working var i, mod 2^32. The digest register persists for chaining.
- WRITE: 8 cycles; out_addr 0..7, out_data = digest word, out_en = out_we = 1.
- DONE: done = 1 for one cycle, then -> IDLE.
- Digest register reset value is the SHA-256 IV (6a09e667 … 5be0cd19), so chain=1 after reset hashes from the standard IV.

## Timing
- Reset values:
  - All strobes low: hmem_en, kmem_en, w_ready, out_en, out_we, done, busy = 0.
  - All addresses and out_data = 0; state = IDLE; t = 0.
- Reset mid-operation aborts on the next edge. There is no partial write-out and no done pulse.
- Latency:
  - start -> first round: 9 cycles (chain=0), 1 cycle (chain=1) for the K prefetch.
  - Rounds take NUM_ROUNDS cycles with w_valid held high.
  - FINAL takes 1 cycle; WRITE takes 8 cycles; done follows the last write.
- Unstalled 64-round block: start -> done = 83 cycles (chain=0), 75 cycles (chain=1).
- w_ready never asserts outside ROUND. W words offered outside ROUND are not consumed.
- start coinciding with done is ignored; start is accepted the cycle after, in IDLE.
- t wraps only by leaving ROUND; t is cleared on entering ROUND.

## Test plan
- Single block "abc" (W from padded 616263 80…18), chain=0 with H = IV -> out words 0..7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done at cycle 83.
- Two-block "abcdbcdecdefghijklmnopq…nopq" (448 bits): block 1 with chain=0, block 2 with chain=1 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- "abc" with w_valid deasserted on random cycles (50% density) -> same digest; t and kmem_addr frozen during each stall; done delayed exactly by the stall count.
- Reset asserted at round 30, then "abc" restarted -> no out_en or done from the aborted block; correct digest from the restart.
- start pulsed during ROUND and WRITE -> ignored; busy stays high; only one done pulse.
- Chain=1 immediately after reset on "abc" W stream -> the standard "abc" digest, proving the IV reset value.
